// File: rtl/sram_march_bist_if.sv
// Port-0 bus between the March C- BIST engine and one SRAM macro.
// master drives the macro pins; slave is the macro side returning registered read data.
interface sram_march_bist_if #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4
);
  logic                   csb0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic [DATA_WIDTH-1:0]  rdata;

  modport master (
    output csb0, web0, wmask0, addr0, din0,
    input  rdata
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0,
    output rdata
  );
endinterface

// File: rtl/sram_march_bist.sv
// March C- self-test engine for one SRAM macro: sequences w0 / r0,w1 / r1,w0 / v r0,w1 /
// v r1,w0 / r0 over 0..addr_max and compares delayed read data against the expected pattern.
module sram_march_bist #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WMASK_WIDTH  = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_max,
  sram_march_bist_if.master     sram,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            fail_count
);

  localparam int unsigned DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_M0    = 4'd1;
  localparam logic [3:0] ST_M1    = 4'd2;
  localparam logic [3:0] ST_M2    = 4'd3;
  localparam logic [3:0] ST_M3    = 4'd4;
  localparam logic [3:0] ST_M4    = 4'd5;
  localparam logic [3:0] ST_M5    = 4'd6;
  localparam logic [3:0] ST_DRAIN = 4'd7;
  localparam logic [3:0] ST_DONE  = 4'd8;

  logic [3:0]            state_q, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [ADDR_WIDTH-1:0] amax_q, amax_n;
  logic                  phase_q, phase_n;
  logic [DCW-1:0]        drain_q, drain_n;
  logic                  accept;

  logic                  two_op, down, nxt_down, last_addr;
  logic [3:0]            elem_nxt;
  logic                  op_act, op_rd, op_val;

  logic                  rd_q, exp_q;
  logic [READ_LATENCY-1:0] pv, pexp;
  logic [ADDR_WIDTH-1:0] paddr [READ_LATENCY];
  logic [DATA_WIDTH-1:0] cmp_diff;
  logic                  miss;

  // Shape of the element currently running: op count, direction, successor.
  always_comb begin
    two_op   = 1'b0;
    down     = 1'b0;
    nxt_down = 1'b0;
    elem_nxt = ST_DRAIN;
    case (state_q)
      ST_M0: elem_nxt = ST_M1;
      ST_M1: begin two_op = 1'b1; elem_nxt = ST_M2; end
      ST_M2: begin two_op = 1'b1; elem_nxt = ST_M3; nxt_down = 1'b1; end
      ST_M3: begin two_op = 1'b1; down = 1'b1; elem_nxt = ST_M4; nxt_down = 1'b1; end
      ST_M4: begin two_op = 1'b1; down = 1'b1; elem_nxt = ST_M5; end
      default: ;
    endcase
  end

  assign last_addr = down ? (addr_q == '0) : (addr_q == amax_q);

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    phase_n = phase_q;
    drain_n = drain_q;
    amax_n  = amax_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = ST_M0;
          addr_n  = '0;
          phase_n = 1'b0;
          amax_n  = addr_max;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        if (two_op && !phase_q) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          // Terminal address ends the element; counters never wrap.
          if (last_addr) begin
            state_n = elem_nxt;
            addr_n  = nxt_down ? amax_q : '0;
            drain_n = '0;
          end else if (down) begin
            addr_n = addr_q - ADDR_WIDTH'(1);
          end else begin
            addr_n = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCW'(READ_LATENCY - 1)) state_n = ST_DONE;
        else                                   drain_n = drain_q + DCW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Operation to present next cycle, decoded from the upcoming element/phase.
  always_comb begin
    op_act = 1'b1;
    op_rd  = 1'b0;
    op_val = 1'b0;
    case (state_n)
      ST_M0: ;
      ST_M1, ST_M3: begin op_rd = !phase_n; op_val = phase_n;  end
      ST_M2, ST_M4: begin op_rd = !phase_n; op_val = !phase_n; end
      ST_M5: op_rd = 1'b1;
      default: op_act = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      amax_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      amax_q  <= amax_n;
      phase_q <= phase_n;
      drain_q <= drain_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram.csb0   <= 1'b1;
      sram.web0   <= 1'b1;
      sram.wmask0 <= '1;
      sram.addr0  <= '0;
      sram.din0   <= '0;
      rd_q        <= 1'b0;
      exp_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      sram.csb0   <= !op_act;
      sram.web0   <= !(op_act && !op_rd);
      sram.wmask0 <= '1;
      sram.addr0  <= addr_n;
      sram.din0   <= (op_act && !op_rd) ? {DATA_WIDTH{op_val}} : '0;
      rd_q        <= op_act && op_rd;
      exp_q       <= op_val;
      busy        <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done        <= (state_n == ST_DONE);
    end
  end

  // Read tracking pipe: stage READ_LATENCY-1 lines up with rdata for that read.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv   <= '0;
      pexp <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) paddr[i] <= '0;
    end else begin
      pv[0]    <= rd_q;
      pexp[0]  <= exp_q;
      paddr[0] <= sram.addr0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pv[i]    <= pv[i-1];
        pexp[i]  <= pexp[i-1];
        paddr[i] <= paddr[i-1];
      end
    end
  end

  assign cmp_diff = sram.rdata ^ {DATA_WIDTH{pexp[READ_LATENCY-1]}};
  assign miss     = pv[READ_LATENCY-1] && (cmp_diff != '0);

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      fail_count <= '0;
    end else if (miss) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_addr <= paddr[READ_LATENCY-1];
        fail_data <= cmp_diff;
      end
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: behavioural SRAM with injectable faults, a March C- reference
// model feeding op/result scoreboards, and a negedge monitor that pops and compares.
module tb_sram_march_bist;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] addr_max = '0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [7:0]    fail_count;

  sram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) sram ();

  sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .READ_LATENCY(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .addr_max   (addr_max),
    .sram       (sram),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; int addr; bit val; } op_t;
  typedef struct { int cyc; bit fl; int fa; bit [31:0] fd; int fc; } res_t;

  op_t  exp_ops[$];
  res_t res_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   edge_cnt = 0;
  int   start_edge = 0;
  bit   done_d = 1'b0;
  int   fmode = 0;   // 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 all reads return 0
  int   faddr = 0;
  int   fbit = 0;
  logic [31:0] mem [1024];
  logic [31:0] dout_q = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now());
    end
  endtask

  function automatic int cyc_now();
    return edge_cnt - start_edge + 1;
  endfunction

  function automatic logic [31:0] fault_rd(input logic [31:0] v, input int a);
    logic [31:0] r;
    r = v;
    case (fmode)
      1: if (a == faddr) r[fbit] = 1'b1;
      2: if (a == faddr) r[fbit] = 1'b0;
      3: r = '0;
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk) edge_cnt++;

  // SRAM: macro read register then capture flop, two cycles from issue to rdata.
  always @(posedge clk) begin
    if (sram.csb0 == 1'b0) begin
      if (sram.web0 == 1'b0) begin
        for (int b = 0; b < int'(MW); b++)
          if (sram.wmask0[b]) mem[sram.addr0][8*b +: 8] <= sram.din0[8*b +: 8];
      end else begin
        dout_q <= fault_rd(mem[sram.addr0], int'(sram.addr0));
      end
    end
    sram.rdata <= dout_q;
  end

  // Reference: walk the six March C- elements over an array model of the memory.
  task automatic model(input int amax, output res_t r);
    logic [31:0] rm [1024];
    logic [31:0] got, ev;
    op_t o;
    int nops, a, nk;
    bit rd, v;
    nops = 0;
    r.fl = 1'b0; r.fa = 0; r.fd = '0; r.fc = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i <= amax; i++) begin
        a  = (e == 3 || e == 4) ? amax - i : i;
        nk = (e == 0 || e == 5) ? 1 : 2;
        for (int k = 0; k < nk; k++) begin
          if (e == 0)      begin rd = 1'b0; v = 1'b0; end
          else if (e == 5) begin rd = 1'b1; v = 1'b0; end
          else if (k == 0) begin rd = 1'b1; v = (e == 2 || e == 4); end
          else             begin rd = 1'b0; v = (e == 1 || e == 3); end
          o.wr = !rd; o.addr = a; o.val = v;
          exp_ops.push_back(o);
          nops++;
          ev = {32{v}};
          if (rd) begin
            got = fault_rd(rm[a], a);
            if (got != ev) begin
              if (r.fc == 0) begin r.fa = a; r.fd = got ^ ev; end
              r.fl = 1'b1;
              if (r.fc < 255) r.fc++;
            end
          end else begin
            rm[a] = ev;
          end
        end
      end
    end
    r.cyc = nops + int'(RL) + 1;
  endtask

  // Monitor: every active SRAM cycle pops one op; done rising pops one result.
  always @(negedge clk) begin
    op_t  o;
    res_t r;
    if (sram.csb0 == 1'b0) begin
      if (exp_ops.size() == 0) begin
        chk("op_unexpected", 1, 0);
      end else begin
        o = exp_ops.pop_front();
        chk("op_web", sram.web0, !o.wr);
        chk("op_addr", sram.addr0, o.addr);
        if (o.wr) begin
          chk("op_din", sram.din0, {32{o.val}});
          chk("op_wmask", sram.wmask0, 4'hF);
        end
      end
    end
    if (done && !done_d) begin
      if (res_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        r = res_q.pop_front();
        chk("done_cycle", cyc_now(), r.cyc);
        chk("busy_at_done", busy, 0);
        chk("fail", fail, r.fl);
        chk("fail_addr", fail_addr, r.fa);
        chk("fail_data", fail_data, r.fd);
        chk("fail_count", fail_count, r.fc);
      end
    end
    done_d = done;
  end

  task automatic run_test(input int amax, input int fm, input int fa, input int fb,
                          input int restart_at, input int reset_at);
    res_t r;
    int budget;
    fmode = fm; faddr = fa; fbit = fb;
    model(amax, r);
    res_q.push_back(r);
    @(negedge clk);
    addr_max   = AW'(amax);
    start_edge = edge_cnt + 1;
    start      = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    addr_max = AW'($urandom_range(0, 1023));
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_fail_clr", fail, 0);
    chk("start_count_clr", fail_count, 0);
    if (restart_at > 0) begin
      while (cyc_now() < restart_at) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (reset_at > 0) begin
      while (cyc_now() < reset_at) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_csb0", sram.csb0, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", fail_count, 0);
      reset = 1'b0;
      exp_ops.delete();
      res_q.delete();
      return;
    end
    budget = r.cyc + 20;
    while (res_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_timeout", res_q.size(), 0);
    chk("ops_left", exp_ops.size(), 0);
    res_q.delete();
    exp_ops.delete();
    repeat (2) @(negedge clk);
    chk("done_held", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int am;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_csb0", sram.csb0, 1);
    chk("rst_web0", sram.web0, 1);
    chk("rst_wmask0", sram.wmask0, 4'hF);
    chk("rst_addr0", sram.addr0, 0);
    chk("rst_din0", sram.din0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_data", fail_data, 0);
    chk("rst_fail_count", fail_count, 0);
    reset = 1'b0;

    run_test(3, 0, 0, 0, 0, 0);     // clean, done at 43
    run_test(3, 1, 2, 5, 0, 0);     // stuck-at-1 bit 5 at addr 2
    run_test(0, 0, 0, 0, 0, 0);     // single word
    run_test(3, 0, 0, 0, 20, 0);    // start while busy ignored
    run_test(1, 3, 0, 0, 0, 15);    // reset mid-test with failures already counted
    run_test(3, 0, 0, 0, 0, 0);     // clean rerun after reset
    run_test(3, 3, 0, 0, 0, 0);     // all reads 0
    run_test(0, 2, 0, 31, 0, 0);
    run_test(199, 3, 0, 0, 0, 0);   // fail_count saturation
    for (int t = 0; t < 10; t++) begin
      am = int'($urandom_range(0, 15));
      run_test(am, int'($urandom_range(0, 3)), int'($urandom_range(0, am)),
               int'($urandom_range(0, 31)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
